inst_sequencer: RTL
===================

Name: inst_sequencer

Overview:
- Instruction issuer on the far side of the processor control unit's run/reg_inst/done handshake.
- Holds a small program memory that is loaded over a write port, and fetches instructions in order.
- Presents each instruction with run asserted and holds it until the control unit pulses done, then advances.
- Stops on a HALT-format word or at the end of memory, and reports progress to the top level.

Parameters:
- DEPTH, 16, number of 16-bit program words (power of two, at least 2).
- AW, 4, address width; equals log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load_en  input  1  write load_data into program memory at load_addr.
- load_addr  input  AW  program memory write address.
- load_data  input  16  instruction word to store.
- start  input  1  begin execution from address 0 (single-cycle pulse or level).
- abort  input  1  cancel execution and return to IDLE.
- cu_done  input  1  done pulse from the control unit; marks the end of its instruction cycle.
- inst_out  output  16  instruction presented to the control unit.
- run  output  1  instruction on inst_out is valid and must be executed.
- busy  output  1  high in FETCH and ISSUE.
- prog_done  output  1  high while in HALT.
- pc  output  AW  address of the current instruction.
- issued_count  output  16  count of instructions completed since the last start.
- load_err  output  1  one-cycle pulse when a load is attempted while busy.

Behaviour:
- Instruction word fields: [15:13] destination register; [12:10] source register (format 00); [12:5] immediate (format 01); [4:2] ALU op; [1:0] format.
- Format encodings: 00 reg-reg, 01 immediate, 10 reserved (issued unchanged), 11 HALT (never issued).
- Reset values: inst_out=0, run=0, busy=0, prog_done=0, pc=0, issued_count=0, load_err=0, state=IDLE. Program memory is not cleared by rst.
- States: IDLE, FETCH, ISSUE, HALT. run and busy are decoded from state; all other outputs are registered.
- IDLE:
  - start -> FETCH, with pc<=0 and issued_count<=0.
  - cu_done is ignored.
- FETCH (exactly 1 cycle):
  - inst_out<=mem[pc]; next state ISSUE.
- ISSUE:
  - If inst_out[1:0]==2'b11: run=0; next state HALT; issued_count unchanged.
  - Otherwise run=1, and inst_out and pc are held stable until cu_done is sampled high.
  - On cu_done with pc==DEPTH-1: issued_count+1; next state HALT.
  - On cu_done otherwise: issued_count+1; pc+1; next state FETCH.
- HALT:
  - prog_done=1 and run=0; inst_out keeps its last value.
  - start -> FETCH with pc<=0 and issued_count<=0.
- Latency:
  - start sampled at edge t -> FETCH in cycle t+1 -> run=1 in cycle t+2.
  - Between consecutive instructions run is low for exactly one cycle (FETCH).
- Loading:
  - In IDLE or HALT, load_en writes mem[load_addr]<=load_data at the clock edge.
  - In FETCH or ISSUE the write is dropped and load_err pulses for 1 cycle.
  - load_en and start in the same cycle: the write completes, and the following FETCH reads the new data (write-before-read).
- Abort:
  - abort in FETCH or ISSUE -> IDLE next cycle; run drops; pc<=0; issued_count holds.
  - abort has priority over a cu_done in the same cycle: no increment and no advance.
  - abort in IDLE or HALT is ignored.
- Priority: abort over start; start while busy is ignored.
- issued_count wraps from 65535 to 0. pc never wraps, because termination occurs at DEPTH-1.
- rst mid-ISSUE: run drops asynchronously to 0 and all outputs return to their reset values.

Test Plan:
- Load mem[0]=16'h2400, mem[1]=16'h4085, mem[2]=16'h0003; start; answer each run with a cu_done 5 cycles later -> two issues with inst_out 16'h2400 then 16'h4085; HALT with issued_count=2, pc=2, run never high for 16'h0003.
- Fill all 16 words with format 00; start; cu_done for each -> 16 issues, prog_done=1, pc=15, issued_count=16, no pc wrap.
- Hold cu_done low for 50 cycles during ISSUE -> run and inst_out stable throughout; cu_done pulse while in IDLE -> no state change.
- Assert abort in the same cycle as cu_done on the second instruction -> IDLE next cycle, issued_count=1, pc=0, run=0.
- load_en during ISSUE to address 1 with 16'hFFFF -> load_err one-cycle pulse, mem[1] unchanged on re-run.
- Assert rst in ISSUE -> run=0 immediately without a clock edge; after release, a start re-executes the retained program from pc=0.

Source files
------------

// File: rtl/inst_sequencer.sv
// -----------------------------------------------------------------------------
// inst_sequencer
//
// Instruction issuer that sits on the far side of the control unit's
// run/reg_inst/done handshake. A small program memory is filled through a
// write port while the sequencer is idle or halted. On start, words are
// fetched in address order and presented to the control unit one at a time.
//
// Handshake: run high means inst_out carries a valid instruction. inst_out
// and pc stay stable for as long as run is high. The instruction is complete
// on the first rising clock edge at which cu_done is sampled high while run
// is high. cu_done at any other time is ignored.
//
// Instruction word: [15:13] dest reg, [12:10] src reg (fmt 00),
// [12:5] immediate (fmt 01), [4:2] ALU op, [1:0] format.
// Format 11 is HALT. A HALT word is never issued.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   load_en/addr/data  program memory write port (honoured in IDLE/HALT)
//   start          begin execution from address 0
//   abort          cancel execution (FETCH/ISSUE only) and return to IDLE
//   cu_done        end-of-instruction pulse from the control unit
//   inst_out       instruction presented to the control unit
//   run            inst_out is valid and must be executed
//   busy           sequencer is in FETCH or ISSUE
//   prog_done      sequencer is in HALT
//   pc             address of the current instruction
//   issued_count   instructions completed since the last start (wraps)
//   load_err       one-cycle pulse for a load attempted while busy
//   dbg_state      current FSM state (IDLE=0, FETCH=1, ISSUE=2, HALT=3)
// -----------------------------------------------------------------------------
module inst_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [15:0]   load_data,
   input  logic          start,
   input  logic          abort,
   input  logic          cu_done,
   output logic [15:0]   inst_out,
   output logic          run,
   output logic          busy,
   output logic          prog_done,
   output logic [AW-1:0] pc,
   output logic [15:0]   issued_count,
   output logic          load_err,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [1:0]    FMT_HALT = 2'b11;
   localparam logic [AW-1:0] LAST_PC  = AW'(DEPTH - 1);

   state_t      state;
   logic [15:0] mem [DEPTH];
   logic        is_halt_word;

   assign is_halt_word = (inst_out[1:0] == FMT_HALT);

   // Decoded straight from state so that an asynchronous reset drops run
   // without waiting for a clock edge.
   assign busy      = (state == S_FETCH) || (state == S_ISSUE);
   assign run       = (state == S_ISSUE) && !is_halt_word;
   assign dbg_state = state;

   // Program memory survives rst. Writes are only accepted while not busy.
   // A write that lands on the same edge as start is visible to the
   // following FETCH, which reads one edge later.
   always_ff @(posedge clk) begin
      if (load_en && !busy) begin
         mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         inst_out     <= 16'h0000;
         pc           <= '0;
         issued_count <= 16'h0000;
         prog_done    <= 1'b0;
         load_err     <= 1'b0;
      end else begin
         load_err <= load_en && busy;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state        <= S_FETCH;
                  pc           <= '0;
                  issued_count <= 16'h0000;
               end
            end

            S_FETCH: begin
               if (abort) begin
                  state <= S_IDLE;
                  pc    <= '0;
               end else begin
                  inst_out <= mem[pc];
                  state    <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               // abort wins over a coincident cu_done: nothing is counted.
               if (abort) begin
                  state <= S_IDLE;
                  pc    <= '0;
               end else if (is_halt_word) begin
                  state     <= S_HALT;
                  prog_done <= 1'b1;
               end else if (cu_done) begin
                  issued_count <= issued_count + 16'd1;
                  // The last word ends the program so pc never wraps.
                  if (pc == LAST_PC) begin
                     state     <= S_HALT;
                     prog_done <= 1'b1;
                  end else begin
                     pc    <= pc + AW'(1);
                     state <= S_FETCH;
                  end
               end
            end

            S_HALT: begin
               if (start) begin
                  state        <= S_FETCH;
                  pc           <= '0;
                  issued_count <= 16'h0000;
                  prog_done    <= 1'b0;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
